// File: rtl/daq_usb_streamer.sv
// rtl/daq_usb_streamer.sv - DAQ frame forwarder from the packetizer FIFO to an FX2 slave FIFO
// Locks onto the two-byte preamble, writes one byte per SLWR strobe and closes each frame with PKTEND.
module daq_usb_streamer #(
   parameter int          FRAME_BYTES = 130,
   parameter logic [7:0]  PREAMBLE    = 8'hAA,
   parameter logic [1:0]  FIFOADR     = 2'b10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        en_i,
   input  logic        fifo_empty_i,
   output logic        fifo_rd_en_o,
   input  logic [7:0]  fifo_dout_i,
   input  logic        fx2_full_n_i,
   output logic        fx2_slwr_n_o,
   output logic        fx2_pktend_n_o,
   output logic [7:0]  fx2_fd_o,
   output logic [1:0]  fx2_fifoadr_o,
   output logic        busy_o,
   output logic        sync_err_o,
   output logic [15:0] sync_err_cnt_o,
   output logic [15:0] frame_cnt_o
);

   localparam int PW = $clog2(FRAME_BYTES);
   localparam logic [PW-1:0] PAY_LAST = PW'(FRAME_BYTES - 2);

   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] HUNT_RD  = 4'd1;
   localparam logic [3:0] HUNT_CHK = 4'd2;
   localparam logic [3:0] PRE0     = 4'd3;
   localparam logic [3:0] PRE1     = 4'd4;
   localparam logic [3:0] PAY_RD   = 4'd5;
   localparam logic [3:0] PAY_LAT  = 4'd6;
   localparam logic [3:0] PAY_WR   = 4'd7;
   localparam logic [3:0] PKTEND   = 4'd8;

   logic [3:0]    state_q, state_d;
   logic [1:0]    aa_cnt_q, aa_cnt_d;
   logic [PW-1:0] pay_cnt_q, pay_cnt_d;
   logic [7:0]    fd_q, fd_d;
   logic          setup_q, setup_d;
   logic          err_armed_q, err_armed_d;
   logic          sync_err_q, sync_err_d;
   logic [15:0]   sync_err_cnt_q, sync_err_cnt_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          wr_state, wr_strobe, pkt_strobe;

   // setup_q is low for the single cycle right after fd_q is reloaded, so
   // the bus always holds a byte for one full cycle before SLWR drops.
   assign wr_state   = (state_q == PRE0) || (state_q == PRE1) || (state_q == PAY_WR);
   assign wr_strobe  = wr_state && fx2_full_n_i && setup_q;
   assign pkt_strobe = (state_q == PKTEND) && fx2_full_n_i;

   assign fifo_rd_en_o   = ((state_q == HUNT_RD) || (state_q == PAY_RD)) && !fifo_empty_i;
   assign fx2_slwr_n_o   = !wr_strobe;
   assign fx2_pktend_n_o = !pkt_strobe;
   assign fx2_fd_o       = fd_q;
   assign fx2_fifoadr_o  = FIFOADR;
   assign busy_o         = (state_q != IDLE);
   assign sync_err_o     = sync_err_q;
   assign sync_err_cnt_o = sync_err_cnt_q;
   assign frame_cnt_o    = frame_cnt_q;

   always_comb begin
      state_d        = state_q;
      aa_cnt_d       = aa_cnt_q;
      pay_cnt_d      = pay_cnt_q;
      fd_d           = fd_q;
      setup_d        = 1'b1;
      err_armed_d    = err_armed_q;
      sync_err_d     = 1'b0;
      sync_err_cnt_d = sync_err_cnt_q;
      frame_cnt_d    = frame_cnt_q;
      case (state_q)
         IDLE: begin
            if (en_i) begin
               state_d     = HUNT_RD;
               aa_cnt_d    = 2'd0;
               pay_cnt_d   = '0;
               err_armed_d = 1'b1;
            end
         end
         HUNT_RD: begin
            if (!fifo_empty_i) state_d = HUNT_CHK;
         end
         HUNT_CHK: begin
            if (fifo_dout_i == PREAMBLE) begin
               aa_cnt_d = aa_cnt_q + 2'd1;
               if (aa_cnt_d == 2'd2) begin
                  state_d   = PRE0;
                  aa_cnt_d  = 2'd0;
                  pay_cnt_d = '0;
                  fd_d      = PREAMBLE;
                  setup_d   = 1'b0;
               end else begin
                  state_d = HUNT_RD;
               end
            end else begin
               aa_cnt_d = 2'd0;
               state_d  = HUNT_RD;
               if (err_armed_q) begin
                  err_armed_d = 1'b0;
                  sync_err_d  = 1'b1;
                  if (sync_err_cnt_q != 16'hFFFF) sync_err_cnt_d = sync_err_cnt_q + 16'd1;
               end
            end
         end
         PRE0: begin
            if (wr_strobe) state_d = PRE1;
         end
         PRE1: begin
            if (wr_strobe) state_d = PAY_RD;
         end
         PAY_RD: begin
            if (!fifo_empty_i) state_d = PAY_LAT;
         end
         PAY_LAT: begin
            fd_d    = fifo_dout_i;
            setup_d = 1'b0;
            state_d = PAY_WR;
         end
         PAY_WR: begin
            if (wr_strobe) begin
               pay_cnt_d = pay_cnt_q + PW'(1);
               state_d   = (pay_cnt_d == PAY_LAST) ? PKTEND : PAY_RD;
            end
         end
         PKTEND: begin
            if (pkt_strobe) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               pay_cnt_d   = '0;
               if (en_i) begin
                  state_d     = HUNT_RD;
                  aa_cnt_d    = 2'd0;
                  err_armed_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= IDLE;
         aa_cnt_q       <= 2'd0;
         pay_cnt_q      <= '0;
         fd_q           <= 8'h00;
         setup_q        <= 1'b0;
         err_armed_q    <= 1'b0;
         sync_err_q     <= 1'b0;
         sync_err_cnt_q <= 16'h0000;
         frame_cnt_q    <= 16'h0000;
      end else begin
         state_q        <= state_d;
         aa_cnt_q       <= aa_cnt_d;
         pay_cnt_q      <= pay_cnt_d;
         fd_q           <= fd_d;
         setup_q        <= setup_d;
         err_armed_q    <= err_armed_d;
         sync_err_q     <= sync_err_d;
         sync_err_cnt_q <= sync_err_cnt_d;
         frame_cnt_q    <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_daq_usb_streamer.sv
// tb/tb_daq_usb_streamer.sv - scoreboard bench for daq_usb_streamer
// A bench-side FIFO feeds the DUT; expected FX2 bytes and PKTEND markers are queued as stimulus is pushed.
module tb_daq_usb_streamer;

   localparam int PKT_MARK = 256;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        en_i = 1'b0;
   logic        fifo_empty_i;
   logic        fifo_rd_en_o;
   logic [7:0]  fifo_dout_i = 8'h00;
   logic        fx2_full_n_i = 1'b1;
   logic        fx2_slwr_n_o;
   logic        fx2_pktend_n_o;
   logic [7:0]  fx2_fd_o;
   logic [1:0]  fx2_fifoadr_o;
   logic        busy_o;
   logic        sync_err_o;
   logic [15:0] sync_err_cnt_o;
   logic [15:0] frame_cnt_o;

   logic [7:0]  mem [0:2047];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        empty_force = 1'b0;
   logic        fifo_flush = 1'b0;

   int          exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          strobes = 0;
   int          pktends = 0;
   int          err_pulses = 0;
   logic [7:0]  fd_prev = 8'h00;

   always #5 clk = ~clk;

   daq_usb_streamer dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .en_i           (en_i),
      .fifo_empty_i   (fifo_empty_i),
      .fifo_rd_en_o   (fifo_rd_en_o),
      .fifo_dout_i    (fifo_dout_i),
      .fx2_full_n_i   (fx2_full_n_i),
      .fx2_slwr_n_o   (fx2_slwr_n_o),
      .fx2_pktend_n_o (fx2_pktend_n_o),
      .fx2_fd_o       (fx2_fd_o),
      .fx2_fifoadr_o  (fx2_fifoadr_o),
      .busy_o         (busy_o),
      .sync_err_o     (sync_err_o),
      .sync_err_cnt_o (sync_err_cnt_o),
      .frame_cnt_o    (frame_cnt_o)
   );

   assign fifo_empty_i = (rd_ptr == wr_ptr) || empty_force;

   // Standard-read FIFO model: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (fifo_flush) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_rd_en_o) begin
         fifo_dout_i <= mem[rd_ptr[10:0]];
         rd_ptr      <= rd_ptr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic monitor();
      int item;
      if (!reset_i) begin
         if (fifo_rd_en_o) check("rd_when_empty", fifo_empty_i, 0);
         if (!fx2_slwr_n_o) begin
            check("slwr_while_full", fx2_full_n_i, 1);
            check("fd_setup", fx2_fd_o, fd_prev);
            item = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD;
            check("fd_byte", fx2_fd_o, item);
            strobes++;
         end
         if (!fx2_pktend_n_o) begin
            item = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD;
            check("pktend_position", item, PKT_MARK);
            pktends++;
         end
         if (sync_err_o) err_pulses++;
      end
      fd_prev = fx2_fd_o;
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit expect_wr);
      mem[wr_ptr[10:0]] = b;
      wr_ptr++;
      if (expect_wr) exp_q.push_back(int'(b));
   endtask

   task automatic push_payload(input int n_expected);
      for (int i = 0; i < 128; i++) push_byte(8'(i), i < n_expected);
      if (n_expected == 128) exp_q.push_back(PKT_MARK);
   endtask

   task automatic wait_drain(input string tag);
      int budget = 3000;
      while (exp_q.size() != 0 && budget > 0) begin
         cycle();
         budget--;
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic wait_strobes(input string tag, input int target);
      int budget = 3000;
      while (strobes < target && budget > 0) begin
         cycle();
         budget--;
      end
      check(tag, strobes >= target, 1);
   endtask

   int base;

   initial begin
      // Reset
      cycle();
      cycle();
      reset_i = 1'b0;
      check("rst_slwr_n", fx2_slwr_n_o, 1);
      check("rst_pktend_n", fx2_pktend_n_o, 1);
      check("rst_rd_en", fifo_rd_en_o, 0);
      check("rst_fd", fx2_fd_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_sync_err", sync_err_o, 0);
      check("rst_sync_err_cnt", sync_err_cnt_o, 0);
      check("rst_frame_cnt", frame_cnt_o, 0);
      check("fifoadr", fx2_fifoadr_o, 2'b10);

      // Clean frame
      base = strobes;
      push_byte(8'hAA, 1);
      push_byte(8'hAA, 1);
      push_payload(128);
      en_i = 1'b1;
      wait_drain("clean_drain");
      check("clean_strobes", strobes - base, 130);
      check("clean_frame_cnt", frame_cnt_o, 1);
      check("clean_sync_err_cnt", sync_err_cnt_o, 0);
      check("clean_err_pulses", err_pulses, 0);

      // Misaligned start
      base = strobes;
      push_byte(8'h12, 0);
      push_byte(8'h34, 0);
      push_byte(8'hAA, 0);
      push_byte(8'h56, 0);
      push_byte(8'hAA, 1);
      push_byte(8'hAA, 1);
      push_payload(128);
      wait_drain("misalign_drain");
      check("misalign_strobes", strobes - base, 130);
      check("misalign_sync_err_cnt", sync_err_cnt_o, 1);
      check("misalign_err_pulses", err_pulses, 1);
      check("misalign_frame_cnt", frame_cnt_o, 2);

      // Backpressure after payload byte 20
      base = strobes;
      push_byte(8'hAA, 1);
      push_byte(8'hAA, 1);
      push_payload(128);
      wait_strobes("bp_reach", base + 2 + 21);
      fx2_full_n_i = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      check("bp_no_strobes", strobes - base, 2 + 21);
      check("bp_fd_held", fx2_fd_o, 21);
      fx2_full_n_i = 1'b1;
      wait_drain("bp_drain");
      check("bp_strobes", strobes - base, 130);
      check("bp_frame_cnt", frame_cnt_o, 3);

      // FIFO underflow mid-payload
      base = strobes;
      push_byte(8'hAA, 1);
      push_byte(8'hAA, 1);
      push_payload(128);
      wait_strobes("uf_reach", base + 2 + 40);
      empty_force = 1'b1;
      for (int i = 0; i < 15; i++) cycle();
      check("uf_no_strobes", strobes - base, 2 + 40);
      check("uf_rd_en_low", fifo_rd_en_o, 0);
      empty_force = 1'b0;
      wait_drain("uf_drain");
      check("uf_strobes", strobes - base, 130);
      check("uf_frame_cnt", frame_cnt_o, 4);

      // en_i dropped mid-frame: frame still completes, then IDLE
      base = strobes;
      push_byte(8'hAA, 1);
      push_byte(8'hAA, 1);
      push_payload(128);
      wait_strobes("endrop_reach", base + 2 + 51);
      en_i = 1'b0;
      wait_drain("endrop_drain");
      cycle();
      cycle();
      check("endrop_strobes", strobes - base, 130);
      check("endrop_frame_cnt", frame_cnt_o, 5);
      check("endrop_idle", busy_o, 0);

      // Reset mid-frame: abort with no PKTEND
      base = pktends;
      en_i = 1'b1;
      push_byte(8'hAA, 1);
      push_byte(8'hAA, 1);
      push_payload(51);
      wait_strobes("rst_mid_reach", strobes + 53);
      reset_i = 1'b1;
      cycle();
      check("rst_mid_busy", busy_o, 0);
      check("rst_mid_slwr_n", fx2_slwr_n_o, 1);
      check("rst_mid_pktend_n", fx2_pktend_n_o, 1);
      check("rst_mid_frame_cnt", frame_cnt_o, 0);
      reset_i = 1'b0;
      en_i = 1'b0;
      fifo_flush = 1'b1;
      cycle();
      fifo_flush = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      check("rst_mid_no_pktend", pktends - base, 0);
      check("rst_mid_scoreboard", exp_q.size(), 0);
      check("rst_mid_idle", busy_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
